// File: rtl/window_3x3_gen.sv
// window_3x3_gen
//   Turns a raster pixel stream into 3x3 neighbourhood windows. Two line
//   buffers hold the previous two rows. A 3x3 register window shifts one
//   column per accepted pixel. A window is emitted once two full rows and
//   two columns of context exist. There is no border padding.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   sof          start of frame, qualified by pix_valid; pixel is (0,0)
//   pix_valid    pix_in accepted this cycle (no backpressure)
//   pix_in       raster-order pixel, DATA_W bits
//   window       9*DATA_W bus; element k (1..9) at [DATA_W*k-1 : DATA_W*(k-1)]
//                 1..3 = row r-2, 4..6 = row r-1, 7..9 = row r; columns c-2..c
//   window_valid one-cycle pulse; window carries a new neighbourhood
module window_3x3_gen #(
  parameter int unsigned IMG_WIDTH = 640,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sof,
  input  logic                  pix_valid,
  input  logic [DATA_W-1:0]     pix_in,
  output logic [9*DATA_W-1:0]   window,
  output logic                  window_valid
);

  localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned WIN_W = 9 * DATA_W;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(2);
  localparam logic [1:0]       ROWS_MAX = 2'd2;

  // Position counters
  logic [COL_W-1:0] col_q, col_d, col_cur_c;
  logic [1:0]       rows_q, rows_d, rows_cur_c;
  logic             accept_c;

  // Line buffers: lb0 holds row r-1, lb1 holds row r-2 (no reset, RAM-like)
  logic [DATA_W-1:0] lb0_mem [IMG_WIDTH];
  logic [DATA_W-1:0] lb1_mem [IMG_WIDTH];
  logic [DATA_W-1:0] lb0_rd_c, lb1_rd_c;

  // 3x3 window registers, index 0..8 = element 1..9
  logic [DATA_W-1:0] win_q [9];
  logic [DATA_W-1:0] win_d [9];

  // Output registers
  logic [WIN_W-1:0] window_q, window_d;
  logic             window_valid_q, window_valid_d;

  assign accept_c = pix_valid;

  // A qualified sof restarts the position at (0,0) for this very pixel
  assign col_cur_c  = (pix_valid && sof) ? '0 : col_q;
  assign rows_cur_c = (pix_valid && sof) ? '0 : rows_q;

  // Read-before-write: reads see contents from before this pixel's write
  assign lb0_rd_c = lb0_mem[col_cur_c];
  assign lb1_rd_c = lb1_mem[col_cur_c];

  // Counter next-state
  always_comb begin
    col_d  = col_q;
    rows_d = rows_q;
    if (accept_c) begin
      if (col_cur_c == COL_LAST) begin
        col_d  = '0;
        rows_d = (rows_cur_c == ROWS_MAX) ? ROWS_MAX : rows_cur_c + 2'd1;
      end else begin
        col_d  = col_cur_c + COL_W'(1);
        rows_d = rows_cur_c;
      end
    end
  end

  // Window shift and output next-state
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      win_d[i] = win_q[i];
    end
    window_d       = window_q;
    window_valid_d = 1'b0;
    if (accept_c) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb1_rd_c;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb0_rd_c;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_in;
      // Columns 0/1 still carry the previous row's right edge, so they never emit
      window_valid_d = (rows_cur_c == ROWS_MAX) && (col_cur_c >= COL_MIN);
    end
    if (window_valid_d) begin
      window_d = {win_d[8], win_d[7], win_d[6],
                  win_d[5], win_d[4], win_d[3],
                  win_d[2], win_d[1], win_d[0]};
    end
  end

  // Control and window state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q          <= '0;
      rows_q         <= '0;
      window_q       <= '0;
      window_valid_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q          <= col_d;
      rows_q         <= rows_d;
      window_q       <= window_d;
      window_valid_q <= window_valid_d;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  // Line-buffer writes: new pixel into lb0, displaced row moves down to lb1
  always_ff @(posedge clk) begin
    if (accept_c) begin
      lb0_mem[col_cur_c] <= pix_in;
      lb1_mem[col_cur_c] <= lb0_rd_c;
    end
  end

  assign window       = window_q;
  assign window_valid = window_valid_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen
//   Directed plus randomized stimulus for window_3x3_gen (IMG_WIDTH=4).
//   A reference model stores the pixels of the last three rows by logical
//   (row, col). It forms the expected window directly from those
//   coordinates and checks every cycle.
module tb_window_3x3_gen;

  localparam int unsigned W     = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned WIN_W = 9 * DW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sof;
  logic             pix_valid;
  logic [DW-1:0]    pix_in;
  logic [WIN_W-1:0] window;
  logic             window_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0]    img [3][W];
  int               m_r, m_c;
  logic             exp_valid;
  logic [WIN_W-1:0] exp_win;
  int               n_win;
  logic [WIN_W-1:0] win_log [$];

  window_3x3_gen #(.IMG_WIDTH(W), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sof          (sof),
    .pix_valid    (pix_valid),
    .pix_in       (pix_in),
    .window       (window),
    .window_valid (window_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_r = 0; m_c = 0;
    exp_valid = 1'b0;
    exp_win   = '0;
  endtask

  task automatic model_accept(input logic s, input logic [DW-1:0] p);
    if (s) begin m_r = 0; m_c = 0; end
    img[m_r % 3][m_c] = p;
    exp_valid = (m_r >= 2) && (m_c >= 2);
    if (exp_valid) begin
      for (int k = 0; k < 9; k++) begin
        exp_win[k*DW +: DW] = img[(m_r - 2 + k / 3) % 3][m_c - 2 + k % 3];
      end
    end
    m_c++;
    if (m_c == W) begin m_c = 0; m_r++; end
  endtask

  task automatic chk_out();
    n_cmp++;
    assert (window_valid === exp_valid) else begin
      n_err++;
      $error("FAIL window_valid obs=%0b exp=%0b t=%0t", window_valid, exp_valid, $time);
    end
    n_cmp++;
    assert (window === exp_win) else begin
      n_err++;
      $error("FAIL window obs=%h exp=%h t=%0t", window, exp_win, $time);
    end
    if (window_valid === 1'b1) begin
      win_log.push_back(window);
      n_win++;
    end
  endtask

  task automatic chk_eq(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIN_W-1:0] logged(input int i);
    return (win_log.size() > i) ? win_log[i] : 'x;
  endfunction

  // One clock: drive at negedge, update model at posedge, sample 1 time unit later
  task automatic step(input logic s, input logic v, input logic [DW-1:0] p);
    @(negedge clk);
    sof = s; pix_valid = v; pix_in = p;
    @(posedge clk);
    if (v) model_accept(s, p);
    else   exp_valid = 1'b0;
    #1;
    chk_out();
  endtask

  task automatic gaps(input int n);
    for (int g = 0; g < n; g++) step(1'($urandom_range(0, 1)), 1'b0, DW'($urandom));
  endtask

  task automatic scen_start();
    n_win = 0;
    win_log.delete();
  endtask

  task automatic chk_base_windows(input string tag);
    chk_eq({tag, "_count"}, WIN_W'(n_win), WIN_W'(4));
    chk_eq({tag, "_w0"}, logged(0), 72'h22_21_20_12_11_10_02_01_00);
    chk_eq({tag, "_w1"}, logged(1), 72'h23_22_21_13_12_11_03_02_01);
    chk_eq({tag, "_w2"}, logged(2), 72'h32_31_30_22_21_20_12_11_10);
    chk_eq({tag, "_w3"}, logged(3), 72'h33_32_31_23_22_21_13_12_11);
  endtask

  initial begin
    rst_n = 1'b0; sof = 1'b0; pix_valid = 1'b0; pix_in = '0;
    model_reset();
    n_win = 0;
    #12;
    chk_eq("reset_window", window, '0);
    chk_eq("reset_valid", WIN_W'(window_valid), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1) Gap-free 4x4 frame
    scen_start();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++)
        step(1'(r == 0 && c == 0), 1'b1, DW'(16 * r + c));
    step(1'b0, 1'b0, '0);
    chk_base_windows("gapfree");

    // 2) Same frame with 1-3 cycle gaps (random sof while idle must be ignored)
    scen_start();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++) begin
        gaps($urandom_range(1, 3));
        step(1'(r == 0 && c == 0), 1'b1, DW'(16 * r + c));
      end
    gaps(2);
    chk_base_windows("gaps");

    // 3) sof restarts the frame at old-frame position (2,1)
    scen_start();
    for (int i = 0; i < 2 * W + 1; i++)
      step(1'(i == 0), 1'b1, DW'(16 * (i / W) + i % W));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++)
        step(1'(r == 0 && c == 0), 1'b1, DW'(8'h80 + 16 * r + c));
    step(1'b0, 1'b0, '0);
    chk_eq("resof_count", WIN_W'(n_win), WIN_W'(4));
    chk_eq("resof_w0", logged(0), 72'hA2_A1_A0_92_91_90_82_81_80);

    // 4) Asynchronous reset in the middle of row 3
    scen_start();
    for (int i = 0; i < 3 * W + 2; i++)
      step(1'(i == 0), 1'b1, DW'(16 * (i / W) + i % W));
    @(negedge clk);
    sof = 1'b0; pix_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_out();
    @(negedge clk);
    rst_n = 1'b1;
    scen_start();
    for (int i = 0; i < 2 * W + 2; i++) step(1'b0, 1'b1, DW'(8'h40 + i));
    chk_eq("post_rst_10", WIN_W'(n_win), '0);
    step(1'b0, 1'b1, DW'(8'h4A));
    chk_eq("post_rst_11", WIN_W'(n_win), WIN_W'(1));
    chk_eq("post_rst_win", logged(0), 72'h4A_49_48_46_45_44_42_41_40);

    // 5) sof without pix_valid in the middle of row 2
    scen_start();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++) begin
        if (r == 2 && c == 2) step(1'b1, 1'b0, 8'hFF);
        step(1'(r == 0 && c == 0), 1'b1, DW'(16 * r + c));
      end
    step(1'b0, 1'b0, '0);
    chk_base_windows("sof_novalid");

    // 6) Random pixels, random gaps, occasional sof
    scen_start();
    step(1'b1, 1'b1, DW'($urandom));
    for (int i = 0; i < 600; i++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      step(1'(v && ($urandom_range(0, 49) == 0)), v, DW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Upstream neighbour of the 9-element sorter. Converts a raster pixel stream into 3x3 neighbourhood windows.
- Each window is presented on a 72-bit concatenated bus in exactly the packing the sorter consumes on its input bus.
- Uses two internal line buffers plus a 3x3 register window. Emits one window per accepted pixel once two full rows and two columns of context exist. No border padding.

Parameters:
- IMG_WIDTH, 640, pixels per line; >= 3; sets line-buffer depth and column-counter wrap.
- DATA_W, 8, bits per pixel; window bus width is 9*DATA_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sof  input  1  start of frame; qualified by pix_valid; marks the current pixel as row 0, column 0.
- pix_valid  input  1  pix_in is valid this cycle; the pixel is accepted; no backpressure.
- pix_in  input  DATA_W  raster-order pixel.
- window  output  9*DATA_W  3x3 window; element k (1..9) at bits [DATA_W*k-1 : DATA_W*(k-1)].
- window_valid  output  1  one-cycle pulse; window holds a new valid neighbourhood.

Behaviour:
- Reset (rst_n low, asynchronous): window=0, window_valid=0, col_cnt=0, rows_seen=0, all 9 window registers=0. Line-buffer RAM contents are not cleared and are don't-care.
- Counters:
  - col_cnt runs 0..IMG_WIDTH-1. It increments per accepted pixel and wraps to 0 after IMG_WIDTH-1.
  - rows_seen is a 2-bit counter saturating at 2. It increments when col_cnt wraps.
- sof:
  - With pix_valid=1, the pixel is treated as col_cnt=0, rows_seen=0. Counters then advance from there: next col=1.
  - sof with pix_valid=0 is ignored.
  - sof mid-line discards position state immediately; stale line-buffer data is never emitted, because rows_seen must reach 2 again.
- Line buffers lb0 and lb1, each IMG_WIDTH x DATA_W, addressed by col_cnt, read-before-write. On an accepted pixel at column c:
  - lb0 read gives the pixel at (r-1, c); lb1 read gives the pixel at (r-2, c).
  - Writes: lb0[c] <= pix_in; lb1[c] <= old lb0[c].
- Window registers: three rows of 3-deep shift registers, shifted only on accepted pixels.
  - Top row is fed from lb1, middle row from lb0, bottom row from pix_in.
  - Element mapping for a pixel accepted at (r, c): element 1 = (r-2, c-2), 2 = (r-2, c-1), 3 = (r-2, c), 4 = (r-1, c-2), 5 = (r-1, c-1) (centre), 6 = (r-1, c), 7 = (r, c-2), 8 = (r, c-1), 9 = (r, c).
- Output timing:
  - window and window_valid are registered. Latency is 1 cycle from pixel acceptance.
  - window_valid=1 in the cycle after a pixel accepted with rows_seen==2 and col_cnt>=2 (pre-increment values); otherwise 0.
  - window updates only when window_valid asserts and holds otherwise.
- pix_valid gaps: state frozen; output identical to the gap-free stream apart from timing.
- Boundaries:
  - Column wrap: window columns 0 and 1 of each row produce no valid output. Left-edge context from the previous row's right edge is shifted through but never emitted.
  - Valid windows per frame: (H-2)*(IMG_WIDTH-2) for H rows.
  - Reset mid-frame: the next accepted pixel is treated as (0, 0) even without sof.
- Widths: counters sized by $clog2(IMG_WIDTH). No arithmetic on pixel data.

Test Plan:
- IMG_WIDTH=4; sof on the first pixel; pixels (r, c) = 16r+c, rows 0..3 gap-free -> first window_valid one cycle after pixel (2,2); window=72'h22_21_20_12_11_10_02_01_00; next window=72'h23_22_21_13_12_11_03_02_01.
- Same frame -> exactly 4 window_valid pulses (after (2,2), (2,3), (3,2), (3,3)); last window=72'h33_32_31_23_22_21_13_12_11; none during rows 0-1 or columns 0-1.
- Same frame with random 1-3 cycle pix_valid gaps -> identical sequence of 4 windows; window_valid never asserts during a gap; window holds its value.
- sof reasserted at pixel (2,1), then a new frame of value 0x80+16r+c -> no window_valid until new-frame (2,2); that window=72'hA2_A1_A0_92_91_90_82_81_80.
- rst_n pulsed low asynchronously mid row 3 -> window=0 and window_valid=0 immediately; the next 2*4+2 pixels produce no window_valid; the 11th pixel yields one.
- sof with pix_valid=0 in the middle of row 2 -> ignored; window sequence unchanged from the first scenario.
